// File: rtl/lane_detector_pkg.sv
// Shared lane-detector constants and types.
package lane_detector_pkg;

    localparam int NLANES       = 4;
    localparam int DEBOUNCE_DEF = 4;
    localparam int CW_DEF       = 4;

    typedef logic [CW_DEF-1:0] cnt_t;

endpackage

// File: rtl/lane_debounce.sv
// One lane sensor: 2-flop sync, debounce and rising-edge arrival pulse.
module lane_debounce
    import lane_detector_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic arv
);

    logic       s1;
    logic       s2;
    logic       deb;
    logic [3:0] dcnt;
    logic       flip;

    // The debounced level flips on the DEBOUNCE-th consecutive differing sample.
    assign flip = (s2 != deb) && (dcnt == 4'(DEBOUNCE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            deb  <= 1'b0;
            dcnt <= '0;
            arv  <= 1'b0;
        end else begin
            s1  <= raw;
            s2  <= s1;
            arv <= flip & ~deb;
            if (s2 == deb) begin
                dcnt <= '0;
            end else if (flip) begin
                deb  <= s2;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/lane_detector.sv
// Four-lane queue tracker: debounced arrivals, green-gated departures.
module lane_detector
    import lane_detector_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    arrive,
    input  logic [3:0]    depart,
    input  logic          green,
    output logic          l1,
    output logic          l2,
    output logic          l3,
    output logic          l4,
    output logic [CW+1:0] total,
    output logic          ovf
);

    localparam logic [CW-1:0] CMAX = '1;

    logic [NLANES-1:0] arv;
    logic [NLANES-1:0] dep;
    logic [CW-1:0]     cnt [NLANES];

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        lane_debounce #(
            .DEBOUNCE (DEBOUNCE)
        ) u_deb (
            .clk (clk),
            .rst (rst),
            .raw (arrive[i]),
            .arv (arv[i])
        );
    end

    assign dep = depart & {NLANES{green}};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NLANES; i++) begin
                cnt[i] <= '0;
            end
            ovf <= 1'b0;
        end else begin
            for (int i = 0; i < NLANES; i++) begin
                // Simultaneous arrival and departure cancel out.
                if (arv[i] && !dep[i]) begin
                    if (cnt[i] == CMAX) begin
                        ovf <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else if (dep[i] && !arv[i] && cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        total = '0;
        for (int i = 0; i < NLANES; i++) begin
            total = total + {2'b00, cnt[i]};
        end
    end

    assign l1 = (cnt[0] != '0);
    assign l2 = (cnt[1] != '0);
    assign l3 = (cnt[2] != '0);
    assign l4 = (cnt[3] != '0);

endmodule

// File: tb/tb_lane_detector.sv
// Directed bench for lane_detector (DEBOUNCE=4, CW=4).
module tb_lane_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] arrive;
    logic [3:0] depart;
    logic       green;
    logic       l1;
    logic       l2;
    logic       l3;
    logic       l4;
    logic [5:0] total;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    lane_detector #(
        .DEBOUNCE (4),
        .CW       (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .arrive (arrive),
        .depart (depart),
        .green  (green),
        .l1     (l1),
        .l2     (l2),
        .l3     (l3),
        .l4     (l4),
        .total  (total),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Hold lanes high long enough to count once, then release and settle.
    task automatic car(input logic [3:0] m);
        arrive = m;
        repeat (7) tick();
        arrive = '0;
        repeat (7) tick();
    endtask

    task automatic pulse_dep(input logic [3:0] m, input logic g);
        depart = m;
        green  = g;
        tick();
        depart = '0;
        green  = 1'b0;
    endtask

    initial begin
        rst    = 1'b0;
        arrive = '0;
        depart = '0;
        green  = 1'b0;
        tick();
        do_reset();
        chk("rst_l", int'({l1, l2, l3, l4}), 0);
        chk("rst_total", int'(total), 0);
        chk("rst_ovf", int'(ovf), 0);

        // Arrival latency: increment lands on edge 7.
        arrive = 4'b0001;
        repeat (6) tick();
        chk("s1_l1_e6", int'(l1), 0);
        tick();
        chk("s1_l1_e7", int'(l1), 1);
        chk("s1_total", int'(total), 1);
        repeat (10) tick();
        chk("s1_hold", int'(total), 1);
        arrive = '0;
        repeat (8) tick();

        // Short glitch is rejected.
        do_reset();
        arrive = 4'b0010;
        repeat (3) tick();
        arrive = '0;
        repeat (10) tick();
        chk("s2_l2", int'(l2), 0);
        chk("s2_total", int'(total), 0);

        // Departures gated by green.
        do_reset();
        car(4'b0100);
        car(4'b0100);
        chk("s3_cnt2", int'(total), 2);
        pulse_dep(4'b0100, 1'b0);
        chk("s3_red", int'(total), 2);
        pulse_dep(4'b0100, 1'b1);
        chk("s3_g1", int'(total), 1);
        chk("s3_l3_on", int'(l3), 1);
        pulse_dep(4'b0100, 1'b1);
        chk("s3_g2", int'(total), 0);
        chk("s3_l3_off", int'(l3), 0);
        pulse_dep(4'b0100, 1'b1);
        chk("s3_g3", int'(total), 0);

        // Saturation and overflow.
        do_reset();
        for (int i = 0; i < 15; i++) car(4'b1000);
        chk("s4_full", int'(total), 15);
        chk("s4_ovf0", int'(ovf), 0);
        chk("s4_l4", int'(l4), 1);
        car(4'b1000);
        chk("s4_sat", int'(total), 15);
        chk("s4_ovf1", int'(ovf), 1);
        car(4'b0111);
        chk("s4_total18", int'(total), 18);
        chk("s4_l123", int'({l1, l2, l3}), 7);
        chk("s4_ovf_keep", int'(ovf), 1);

        // Arrival and accepted departure together hold.
        do_reset();
        chk("s5_ovf_clr", int'(ovf), 0);
        for (int i = 0; i < 3; i++) car(4'b0001);
        chk("s5_cnt3", int'(total), 3);
        arrive = 4'b0001;
        repeat (6) tick();
        depart = 4'b0001;
        green  = 1'b1;
        tick();
        depart = '0;
        green  = 1'b0;
        chk("s5_same", int'(total), 3);
        arrive = '0;
        repeat (8) tick();
        chk("s5_after", int'(total), 3);
        pulse_dep(4'b0001, 1'b1);
        chk("s5_dep", int'(total), 2);

        // Reset mid-debounce and mid-count.
        do_reset();
        for (int i = 0; i < 5; i++) car(4'b0001);
        chk("s6_cnt5", int'(total), 5);
        arrive = 4'b0010;
        repeat (3) tick();
        arrive = '0;
        do_reset();
        chk("s6_l", int'({l1, l2, l3, l4}), 0);
        chk("s6_total", int'(total), 0);
        chk("s6_ovf", int'(ovf), 0);
        repeat (15) tick();
        chk("s6_late", int'(total), 0);

        // All four lanes at once.
        car(4'b1111);
        chk("multi", int'(total), 4);

        // Sensor held through reset release.
        arrive = 4'b1000;
        do_reset();
        chk("hold_rst", int'(total), 0);
        repeat (6) tick();
        chk("hold_e6", int'(l4), 0);
        tick();
        chk("hold_e7", int'(l4), 1);
        chk("hold_total", int'(total), 1);
        arrive = '0;
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
